// File: rtl/arm_mc_fsm.sv
// Main sequencing FSM of the multicycle ARM controller: fetch/decode/execute/writeback
// with a memory-ready handshake, a wait timeout and an undefined-opcode trap.
// Optional performance counters are built only when ARM_MC_PERF_EN is defined.
module arm_mc_fsm #(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             Undef,
  output logic             BusErr,
  output logic             Retired,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_UNDEF  = 4'd10
  } state_t;

  localparam bit             TO_EN     = (TIMEOUT != 0);
  localparam logic [TO_W:0]  TIMEOUT_V = (TO_W+1)'(TIMEOUT);
  localparam logic [TO_W:0]  WAIT_ONE  = (TO_W+1)'(1);

  state_t          r_state;
  state_t          w_next_state;
  logic [TO_W-1:0] r_wait_cnt;
  logic [TO_W:0]   w_wait_inc;
  logic            w_wait_state;
  logic            w_timeout;
  logic            w_unused;

  // Only Funct[5] (immediate) and Funct[0] (load) steer the sequence.
  assign w_unused     = ^Funct[4:1];

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // The increment includes the current stalled cycle, so a limit of N aborts on the Nth stall.
  assign w_wait_inc   = {1'b0, r_wait_cnt} + WAIT_ONE;
  assign w_timeout    = TO_EN && w_wait_state && !MemReady && (w_wait_inc == TIMEOUT_V);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset || MemReady || w_timeout || !w_wait_state) r_wait_cnt <= '0;
    else                                                  r_wait_cnt <= w_wait_inc[TO_W-1:0];
  end

  always_comb begin
    // NOTE: assign a default before the case so no path leaves the signal unassigned (no latch).
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next_state = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next_state = S_MEMADR;
          2'b10:   w_next_state = S_BRANCH;
          default: w_next_state = S_UNDEF;
        endcase
      end
      S_MEMADR: w_next_state = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next_state = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next_state = MemReady ? S_FETCH : S_MEMWR;
      S_EXECR:  w_next_state = S_ALUWB;
      S_EXECI:  w_next_state = S_ALUWB;
      default:  w_next_state = S_FETCH;
    endcase
    if (w_timeout) w_next_state = S_FETCH;
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Undef     = 1'b0;
    Retired   = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        Retired   = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
        Retired = MemReady;
      end
      S_EXECR:  ALUOp = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB: begin
        RegW    = 1'b1;
        Retired = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        Retired   = 1'b1;
      end
      S_UNDEF:  Undef = 1'b1;
      default: ;
    endcase
    BusErr = w_timeout;
    // Strobes are suppressed in the reset cycle; the mux selects stay decoded from State.
    if (reset) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      Branch  = 1'b0;
      Undef   = 1'b0;
      BusErr  = 1'b0;
      Retired = 1'b0;
    end
  end

  assign State = r_state;

`ifdef ARM_MC_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_instr_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (Retired)                    r_instr_cnt <= r_instr_cnt + CNT_ONE;
      if (w_wait_state && !MemReady)  r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign InstrCount = r_instr_cnt;
  assign StallCount = r_stall_cnt;
`else
  assign InstrCount = '0;
  assign StallCount = '0;
`endif

endmodule
